// File: rtl/flight_math_pkg.sv
// Shared flight-math types and sign-magnitude helpers.
// Helpers work on MAX_W-wide vectors; callers truncate to the width they need.
package flight_math_pkg;

  localparam int unsigned MAX_W = 128;

  typedef enum logic {
    ACCUM,
    EMIT
  } acc_state_t;

  // Sign-magnitude (sign at bit n-1) to two's complement.
  function automatic logic [MAX_W-1:0] sm_to_tc(input logic [MAX_W-1:0] sm,
                                                input int unsigned      n);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] mag;
    mask     = (MAX_W'(1) << (n - 1)) - MAX_W'(1);
    mag      = sm & mask;
    sm_to_tc = sm[n-1] ? (~mag + MAX_W'(1)) : mag;
  endfunction

  // Two's complement to n-bit sign-magnitude, saturating to full scale.
  function automatic logic [MAX_W-1:0] tc_to_sm_sat(input  logic [MAX_W-1:0] acc,
                                                    input  int unsigned      n,
                                                    output logic             sat);
    logic             neg;
    logic [MAX_W-1:0] mag;
    logic [MAX_W-1:0] limit;
    neg   = acc[MAX_W-1];
    mag   = neg ? (~acc + MAX_W'(1)) : acc;
    limit = (MAX_W'(1) << (n - 1)) - MAX_W'(1);
    sat   = (mag > limit);
    if (sat) mag = limit;
    // A zero magnitude is always reported as +0.
    tc_to_sm_sat = (neg && (mag != '0)) ? (mag | (MAX_W'(1) << (n - 1))) : mag;
  endfunction

endpackage

// File: rtl/smag_accumulator_sm_to_tc.sv
// Combinational sign-magnitude to two's-complement converter.
// -0 maps to 0; the magnitude is zero-extended before negation.
module sm_to_tc #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 35
) (
  input  logic [IN_W-1:0]  i_sm,
  output logic [OUT_W-1:0] o_tc
);

  logic [OUT_W-1:0] w_mag;

  assign w_mag = {{(OUT_W-IN_W+1){1'b0}}, i_sm[IN_W-2:0]};
  assign o_tc  = i_sm[IN_W-1] ? (~w_mag + OUT_W'(1)) : w_mag;

endmodule

// File: rtl/smag_accumulator.sv
// Sums TERMS sign-magnitude products into one saturated sign-magnitude result.
// One result per TERMS accepted products, emitted from a one-cycle EMIT state.
module smag_accumulator
  import flight_math_pkg::*;
#(
  parameter int N     = 32,
  parameter int TERMS = 3
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       en,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [N-1:0]               in_data,
  input  logic                       in_ovf,
  output logic                       in_ready,
  output logic [N-1:0]               sum,
  output logic                       sum_valid,
  output logic                       sat,
  output logic [$clog2(TERMS+1)-1:0] term_idx
);

  localparam int ACC_W = N + $clog2(TERMS) + 1;
  localparam int IW    = $clog2(TERMS + 1);

  acc_state_t       r_state, w_state_n;
  logic [ACC_W-1:0] r_acc, w_acc_n;
  logic             r_ovf, w_ovf_n;
  logic [IW-1:0]    r_idx, w_idx_n;
  logic [N-1:0]     r_sum, w_sum_n;
  logic             r_sat, w_sat_n;
  logic             r_valid, w_valid_n;
  logic [ACC_W-1:0] w_tc;
  logic [N-1:0]     w_conv;
  logic             w_conv_sat;

  sm_to_tc #(
    .IN_W  (N),
    .OUT_W (ACC_W)
  ) u_sm_to_tc (
    .i_sm (in_data),
    .o_tc (w_tc)
  );

  always_comb begin
    w_conv_sat = 1'b0;
    w_conv     = N'(tc_to_sm_sat(MAX_W'($signed(r_acc)), N, w_conv_sat));

    w_state_n = r_state;
    w_acc_n   = r_acc;
    w_ovf_n   = r_ovf;
    w_idx_n   = r_idx;
    w_sum_n   = r_sum;
    w_sat_n   = r_sat;
    w_valid_n = 1'b0;

    if (clear) begin
      w_state_n = ACCUM;
      w_acc_n   = '0;
      w_ovf_n   = 1'b0;
      w_idx_n   = '0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (in_valid) begin
            w_acc_n = r_acc + w_tc;
            w_ovf_n = r_ovf | in_ovf;
            w_idx_n = r_idx + IW'(1);
            if (r_idx == IW'(TERMS - 1)) w_state_n = EMIT;
          end
        end
        EMIT: begin
          w_sum_n   = w_conv;
          w_sat_n   = w_conv_sat | r_ovf;
          w_valid_n = 1'b1;
          w_acc_n   = '0;
          w_ovf_n   = 1'b0;
          w_idx_n   = '0;
          w_state_n = ACCUM;
        end
        default: w_state_n = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_sat   <= 1'b0;
      r_valid <= 1'b0;
    end else if (en) begin
      r_state <= w_state_n;
      r_acc   <= w_acc_n;
      r_ovf   <= w_ovf_n;
      r_idx   <= w_idx_n;
      r_sum   <= w_sum_n;
      r_sat   <= w_sat_n;
      r_valid <= w_valid_n;
    end
  end

  assign in_ready  = (r_state == ACCUM);
  assign sum       = r_sum;
  assign sum_valid = r_valid;
  assign sat       = r_sat;
  assign term_idx  = r_idx;

endmodule

// File: tb/tb_smag_accumulator.sv
// Directed and randomized checks of smag_accumulator (N=32, TERMS=3)
// against an integer-arithmetic reference model.
module tb_smag_accumulator;

  localparam int N     = 32;
  localparam int TERMS = 3;

  logic          clk;
  logic          nrst;
  logic          en;
  logic          clear;
  logic          in_valid;
  logic [N-1:0]  in_data;
  logic          in_ovf;
  logic          in_ready;
  logic [N-1:0]  sum;
  logic          sum_valid;
  logic          sat;
  logic [1:0]    term_idx;

  int unsigned   tests;
  int unsigned   fails;
  logic [N-1:0]  last_sum;

  smag_accumulator #(
    .N     (N),
    .TERMS (TERMS)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .en        (en),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ovf    (in_ovf),
    .in_ready  (in_ready),
    .sum       (sum),
    .sum_valid (sum_valid),
    .sat       (sat),
    .term_idx  (term_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: signed integer sum of the terms, then saturate and re-encode.
  task automatic model(input logic [N-1:0] t[3], input logic o[3],
                       output logic [N-1:0] s, output logic s_sat);
    longint total;
    longint mag;
    logic   any_ovf;
    total   = 0;
    any_ovf = 1'b0;
    for (int i = 0; i < TERMS; i++) begin
      mag = longint'(t[i][N-2:0]);
      total += t[i][N-1] ? -mag : mag;
      any_ovf |= o[i];
    end
    mag = (total < 0) ? -total : total;
    if (mag > 64'sd2147483647) begin
      mag   = 64'sd2147483647;
      s_sat = 1'b1;
    end else begin
      s_sat = any_ovf;
    end
    s = {(total < 0) && (mag != 0), mag[N-2:0]};
  endtask

  task automatic run_sum(input logic [N-1:0] t0, t1, t2, input logic o0, o1, o2,
                         input bit gaps, input string tag);
    logic [N-1:0] t[3];
    logic         o[3];
    logic [N-1:0] es;
    logic         esat;
    t[0] = t0; t[1] = t1; t[2] = t2;
    o[0] = o0; o[1] = o1; o[2] = o2;
    model(t, o, es, esat);
    for (int i = 0; i < TERMS; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      chk({tag, " in_ready"}, in_ready, 1'b1);
      in_valid = 1'b1;
      in_data  = t[i];
      in_ovf   = o[i];
      tick();
      chk({tag, " term_idx"}, term_idx, 64'(i + 1));
      chk({tag, " no early valid"}, sum_valid, 1'b0);
    end
    chk({tag, " emit not ready"}, in_ready, 1'b0);
    in_data = 32'h0001_2345;
    in_ovf  = 1'b1;
    tick();
    in_valid = 1'b0;
    in_ovf   = 1'b0;
    chk({tag, " sum_valid"}, sum_valid, 1'b1);
    chk({tag, " sum"}, sum, es);
    chk({tag, " sat"}, sat, esat);
    chk({tag, " idx cleared"}, term_idx, 2'd0);
    tick();
    chk({tag, " valid drop"}, sum_valid, 1'b0);
    chk({tag, " sum hold"}, sum, es);
    last_sum = es;
  endtask

  function automatic logic [N-1:0] rand_term();
    logic [N-2:0] mag;
    case ($urandom_range(0, 3))
      0:       mag = 31'h7FFF_FFFF - 31'($urandom_range(0, 3));
      1:       mag = 31'($urandom_range(0, 15));
      default: mag = 31'($urandom);
    endcase
    return {1'($urandom_range(0, 1)), mag};
  endfunction

  initial begin
    tests    = 0;
    fails    = 0;
    last_sum = '0;
    nrst     = 1'b0;
    en       = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_ovf   = 1'b0;
    repeat (2) tick();
    chk("rst sum", sum, 32'h0);
    chk("rst sum_valid", sum_valid, 1'b0);
    chk("rst sat", sat, 1'b0);
    chk("rst term_idx", term_idx, 2'd0);
    chk("rst in_ready", in_ready, 1'b1);
    nrst = 1'b1;
    tick();

    run_sum(32'h5, 32'h7, 32'h8000_0002, 0, 0, 0, 0, "t1");
    run_sum(32'h8000_0005, 32'h5, 32'h0, 0, 0, 0, 0, "t2");
    run_sum(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h1, 0, 0, 0, 0, "t3pos");
    run_sum(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 0, 0, 0, 0, "t3neg");
    run_sum(32'h3, 32'h8000_0004, 32'h9, 0, 1, 0, 0, "t4ovf");
    run_sum(32'h3, 32'h8000_0004, 32'h9, 0, 0, 0, 0, "t4clean");

    // Clear with a simultaneous term: partial sum and the term are dropped.
    in_valid = 1'b1;
    in_data  = 32'h9;
    tick();
    tick();
    chk("t5 idx before clear", term_idx, 2'd2);
    clear   = 1'b1;
    in_data = 32'd100;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("t5 idx cleared", term_idx, 2'd0);
    chk("t5 sum kept", sum, last_sum);
    chk("t5 no valid", sum_valid, 1'b0);
    chk("t5 ready", in_ready, 1'b1);
    run_sum(32'h1, 32'h1, 32'h1, 0, 0, 0, 0, "t5");
    chk("t5 sum is 3", sum, 32'h3);

    // Clock-enable hold mid-sum and on the sum_valid cycle.
    in_valid = 1'b1;
    in_data  = 32'd3;
    tick();
    en      = 1'b0;
    in_data = 32'd50;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6 idx hold", term_idx, 2'd1);
    end
    en      = 1'b1;
    in_data = 32'd4;
    tick();
    in_data = 32'd6;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t6 valid", sum_valid, 1'b1);
    chk("t6 sum", sum, 32'd13);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6 valid hold", sum_valid, 1'b1);
      chk("t6 sum hold", sum, 32'd13);
    end
    en = 1'b1;
    tick();
    chk("t6 valid drop", sum_valid, 1'b0);

    // Asynchronous reset mid-sum.
    in_valid = 1'b1;
    in_data  = 32'h8000_0008;
    tick();
    in_valid = 1'b0;
    chk("t6 idx pre-rst", term_idx, 2'd1);
    nrst = 1'b0;
    #1;
    chk("t6 rst idx", term_idx, 2'd0);
    chk("t6 rst sum", sum, 32'h0);
    chk("t6 rst sat", sat, 1'b0);
    chk("t6 rst valid", sum_valid, 1'b0);
    @(negedge clk);
    nrst = 1'b1;
    tick();
    run_sum(32'h1, 32'h2, 32'h3, 0, 0, 0, 0, "t6 post-rst");

    for (int k = 0; k < 25; k++) begin
      run_sum(rand_term(), rand_term(), rand_term(),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 7) == 0), 1, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
